// File: rtl/gpu_font_pkg.sv
// Glyph geometry defaults, controller state encoding and draw-request record shared
// by the glyph address streamer and its accumulators.
package gpu_font_pkg;

  localparam int CHAR_W_DEF         = 64;
  localparam int CHAR_H_DEF         = 128;
  localparam int PIX_PER_WORD_DEF   = 16;
  localparam int CHARS_PER_FONT_DEF = 256;
  localparam int WPC_DEF            = CHAR_W_DEF * CHAR_H_DEF / PIX_PER_WORD_DEF;
  localparam int WPF_DEF            = CHARS_PER_FONT_DEF * WPC_DEF;
  localparam int REQ_FONT_W         = 5;
  localparam int REQ_DIM_W          = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } glyph_state_e;

  typedef struct packed {
    logic [REQ_FONT_W-1:0] font;
    logic [7:0]            chr;
    logic [REQ_DIM_W-1:0]  dst_w;
    logic [REQ_DIM_W-1:0]  dst_h;
    logic [REQ_DIM_W-1:0]  step_x;
    logic [REQ_DIM_W-1:0]  step_y;
  } glyph_req_t;

endpackage

// File: rtl/glyph_step_accum.sv
// DDA accumulator: clear, add one fixed-point step per pixel, and report the integer
// part clamped to the last source texel so oversize destinations never wrap.
module glyph_step_accum #(
  parameter int                 ACC_W     = 32,
  parameter int                 STEP_W    = 16,
  parameter int                 FRAC_W    = 8,
  parameter int                 COORD_W   = 6,
  parameter logic [COORD_W-1:0] COORD_MAX = {COORD_W{1'b1}}
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               step_en,
  input  logic [STEP_W-1:0]  step,
  output logic [COORD_W-1:0] coord
);

  logic [ACC_W-1:0] acc_r;
  logic [ACC_W:0]   sum_s;
  logic [ACC_W-1:0] int_s;

  assign sum_s = {1'b0, acc_r} + (ACC_W+1)'(step);
  assign int_s = acc_r >> FRAC_W;

  // integer part of the accumulator, saturated at the glyph edge
  always_comb begin
    if (int_s > ACC_W'(COORD_MAX)) begin
      coord = COORD_MAX;
    end else begin
      coord = int_s[COORD_W-1:0];
    end
  end

  // accumulator register; clear wins over step, sum sticks at all-ones on overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r <= '0;
    end else if (clr) begin
      acc_r <= '0;
    end else if (step_en) begin
      acc_r <= sum_s[ACC_W] ? {ACC_W{1'b1}} : sum_s[ACC_W-1:0];
    end else begin
      acc_r <= acc_r;
    end
  end

endmodule

// File: rtl/glyph_addr_stream.sv
// Walks a scaled glyph's destination rectangle row-major and streams the flash word
// address and bit of each source texel. Define GLYPH_ADDR_DEDUP_EN to merge same-word pixels.
module glyph_addr_stream
  import gpu_font_pkg::*;
#(
  parameter int CHAR_W         = CHAR_W_DEF,
  parameter int CHAR_H         = CHAR_H_DEF,
  parameter int PIX_PER_WORD   = PIX_PER_WORD_DEF,
  parameter int CHARS_PER_FONT = CHARS_PER_FONT_DEF,
  parameter int ADDR_W         = 22,
  parameter int FONT_W         = REQ_FONT_W,
  parameter int DIM_W          = REQ_DIM_W,
  parameter int FRAC_W         = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [FONT_W-1:0]               req_font,
  input  logic [7:0]                      req_char,
  input  logic [DIM_W-1:0]                req_dst_w,
  input  logic [DIM_W-1:0]                req_dst_h,
  input  logic [DIM_W-1:0]                req_step_x,
  input  logic [DIM_W-1:0]                req_step_y,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ADDR_W-1:0]               out_addr,
  output logic [$clog2(PIX_PER_WORD)-1:0] out_bit,
  output logic [DIM_W-1:0]                out_run,
  output logic                            out_eol,
  output logic                            out_last,
  output logic                            done
);

  localparam int BIT_W   = $clog2(PIX_PER_WORD);
  localparam int CX_W    = $clog2(CHAR_W);
  localparam int CY_W    = $clog2(CHAR_H);
  localparam int WPC     = CHAR_W * CHAR_H / PIX_PER_WORD;
  localparam int CHAR_SH = $clog2(WPC);
  localparam int FONT_SH = $clog2(CHARS_PER_FONT * WPC);
  localparam int ROW_SH  = $clog2(CHAR_W / PIX_PER_WORD);

  localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
  localparam logic [1:0] S_LOAD = 2'(ST_LOAD);
  localparam logic [1:0] S_RUN  = 2'(ST_RUN);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BIT_W-1:0]  bidx;
    logic [DIM_W-1:0]  run;
    logic              eol;
    logic              last;
  } beat_t;

  logic [1:0]        state_r;
  glyph_req_t        req_r;
  logic [ADDR_W-1:0] base_r;
  logic [DIM_W-1:0]  row_r, col_r;
  logic              gen_done_r;
  beat_t             out_r;
  logic              out_valid_r, done_r, req_ready_r;

  logic [CX_W-1:0]   src_x_s;
  logic [CY_W-1:0]   src_y_s;
  beat_t             pix_s, beat_s;
  logic              last_col_s, last_row_s, gen_act_s, out_free_s, adv_s, load_s;

  assign last_col_s = (col_r == (req_r.dst_w - DIM_W'(1)));
  assign last_row_s = (row_r == (req_r.dst_h - DIM_W'(1)));
  assign gen_act_s  = (state_r == S_RUN) && !gen_done_r;
  assign out_free_s = !out_valid_r || out_ready;

  glyph_step_accum #(
    .ACC_W(2*DIM_W), .STEP_W(DIM_W), .FRAC_W(FRAC_W),
    .COORD_W(CX_W), .COORD_MAX(CX_W'(CHAR_W - 1))
  ) u_acc_x (
    .clk(clk), .rst_n(rst_n),
    .clr((state_r == S_LOAD) || (adv_s && last_col_s)),
    .step_en(adv_s && !last_col_s),
    .step(req_r.step_x), .coord(src_x_s)
  );

  glyph_step_accum #(
    .ACC_W(2*DIM_W), .STEP_W(DIM_W), .FRAC_W(FRAC_W),
    .COORD_W(CY_W), .COORD_MAX(CY_W'(CHAR_H - 1))
  ) u_acc_y (
    .clk(clk), .rst_n(rst_n),
    .clr(state_r == S_LOAD),
    .step_en(adv_s && last_col_s),
    .step(req_r.step_y), .coord(src_y_s)
  );

  // texel of the pixel at the current row/column counters
  always_comb begin
    pix_s.addr = base_r + (ADDR_W'(src_y_s) << ROW_SH) + ADDR_W'(src_x_s >> BIT_W);
    pix_s.bidx = src_x_s[BIT_W-1:0];
    pix_s.run  = DIM_W'(1);
    pix_s.eol  = last_col_s;
    pix_s.last = last_col_s && last_row_s;
  end

`ifdef GLYPH_ADDR_DEDUP_EN
  beat_t pend_r;
  logic  pend_valid_r, pend_set_s, pend_merge_s, pend_clr_s, merge_s;

  // a pending beat only grows while it stays inside its row and word
  assign merge_s = pend_valid_r && !pend_r.eol && (pend_r.addr == pix_s.addr);

  // decide pixel advance and which beat, if any, enters the output register
  always_comb begin
    adv_s        = 1'b0;
    load_s       = 1'b0;
    beat_s       = pend_r;
    pend_set_s   = 1'b0;
    pend_merge_s = 1'b0;
    pend_clr_s   = 1'b0;
    if (gen_act_s) begin
      if (merge_s) begin
        adv_s        = 1'b1;
        pend_merge_s = 1'b1;
      end else if (!pend_valid_r) begin
        adv_s      = 1'b1;
        pend_set_s = 1'b1;
      end else if (out_free_s) begin
        adv_s      = 1'b1;
        pend_set_s = 1'b1;
        load_s     = 1'b1;
      end else begin
        adv_s = 1'b0;
      end
    end else if ((state_r == S_RUN) && pend_valid_r && out_free_s) begin
      load_s     = 1'b1;
      pend_clr_s = 1'b1;
    end else begin
      load_s = 1'b0;
    end
  end

  // lookahead beat absorbing consecutive same-word pixels
  always_ff @(posedge clk) begin
    if (!rst_n || (state_r != S_RUN)) begin
      pend_r       <= '0;
      pend_valid_r <= 1'b0;
    end else if (pend_set_s) begin
      pend_r       <= pix_s;
      pend_valid_r <= 1'b1;
    end else if (pend_merge_s) begin
      pend_r.run  <= pend_r.run + DIM_W'(1);
      pend_r.eol  <= pix_s.eol;
      pend_r.last <= pix_s.last;
    end else if (pend_clr_s) begin
      pend_valid_r <= 1'b0;
    end else begin
      pend_valid_r <= pend_valid_r;
    end
  end
`else
  // one beat per pixel whenever the output register can take it
  always_comb begin
    adv_s  = 1'b0;
    load_s = 1'b0;
    beat_s = pix_s;
    if (gen_act_s && out_free_s) begin
      adv_s  = 1'b1;
      load_s = 1'b1;
    end else begin
      adv_s = 1'b0;
    end
  end
`endif

  // request FSM, raster counters and registered output beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      req_r       <= '0;
      base_r      <= '0;
      row_r       <= '0;
      col_r       <= '0;
      gen_done_r  <= 1'b0;
      out_r       <= '0;
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
      req_ready_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          if (req_valid && req_ready_r) begin
            req_r       <= '{font: req_font, chr: req_char, dst_w: req_dst_w,
                             dst_h: req_dst_h, step_x: req_step_x, step_y: req_step_y};
            req_ready_r <= 1'b0;
            state_r     <= S_LOAD;
          end else begin
            req_ready_r <= 1'b1;
          end
        end
        S_LOAD: begin
          base_r     <= (ADDR_W'(req_r.font) << FONT_SH) + (ADDR_W'(req_r.chr) << CHAR_SH);
          row_r      <= '0;
          col_r      <= '0;
          gen_done_r <= 1'b0;
          if ((req_r.dst_w == DIM_W'(0)) || (req_r.dst_h == DIM_W'(0))) begin
            done_r      <= 1'b1;
            req_ready_r <= 1'b1;
            state_r     <= S_IDLE;
          end else begin
            state_r <= S_RUN;
          end
        end
        S_RUN: begin
          if (adv_s) begin
            if (last_col_s) begin
              col_r <= '0;
              if (last_row_s) gen_done_r <= 1'b1;
              else            row_r      <= row_r + DIM_W'(1);
            end else begin
              col_r <= col_r + DIM_W'(1);
            end
          end
          if (out_valid_r && out_ready && out_r.last) begin
            out_valid_r <= 1'b0;
            done_r      <= 1'b1;
            req_ready_r <= 1'b1;
            state_r     <= S_IDLE;
          end else if (load_s) begin
            out_r       <= beat_s;
            out_valid_r <= 1'b1;
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_r;
  assign out_valid = out_valid_r;
  assign out_addr  = out_r.addr;
  assign out_bit   = out_r.bidx;
  assign out_run   = out_r.run;
  assign out_eol   = out_r.eol;
  assign out_last  = out_r.last;
  assign done      = done_r;

endmodule

// File: tb/tb_glyph_addr_stream.sv
// Directed self-checking bench for glyph_addr_stream; per-beat texel model plus
// hand-computed addresses at the interesting pixels.
module tb_glyph_addr_stream;

  logic        clk = 1'b0;
  logic        rst_n, req_valid, req_ready, out_valid, out_ready, out_eol, out_last, done;
  logic [4:0]  req_font;
  logic [7:0]  req_char;
  logic [15:0] req_dst_w, req_dst_h, req_step_x, req_step_y, out_run;
  logic [21:0] out_addr;
  logic [3:0]  out_bit;

  int vec_cnt = 0;
  int err_cnt = 0;
  int beats, eols;
  int log_addr[$];
  int log_bit[$];
  int log_run[$];

  always #5 clk = ~clk;

  glyph_addr_stream dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_font(req_font), .req_char(req_char), .req_dst_w(req_dst_w), .req_dst_h(req_dst_h),
    .req_step_x(req_step_x), .req_step_y(req_step_y), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_bit(out_bit), .out_run(out_run),
    .out_eol(out_eol), .out_last(out_last), .done(done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vec_cnt++;
    assert (obs === expv) else begin
      err_cnt++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic send(input int font, input int chr, input int w, input int h,
                      input int sx, input int sy);
    for (int i = 0; i < 20 && req_ready !== 1'b1; i++) step();
    chk("req_ready_wait", req_ready, 1);
    req_font   = font[4:0];
    req_char   = chr[7:0];
    req_dst_w  = w[15:0];
    req_dst_h  = h[15:0];
    req_step_x = sx[15:0];
    req_step_y = sy[15:0];
    req_valid  = 1'b1;
    step();
    req_valid  = 1'b0;
  endtask

  // consume beats, checking each against the texel model; stop_at >= 0 abandons early
  task automatic drain(input int w, input int h, input int sx, input int sy, input int base,
                       input int stall_at, input int stop_at);
    int r = 0, c = 0, cyc = 0, px, py, ea, eb, run;
    bit fin = 1'b0, stalled = 1'b0;
    beats = 0;
    eols  = 0;
    log_addr.delete();
    log_bit.delete();
    log_run.delete();
    while (!fin && cyc < 20000) begin
      if (beats == stop_at) return;
      if (out_valid === 1'b1) begin
        px = (c * sx) >> 8;
        if (px > 63) px = 63;
        py = (r * sy) >> 8;
        if (py > 127) py = 127;
        ea = base + py * 4 + px / 16;
        eb = px % 16;
        if (beats == stall_at && !stalled) begin
          stalled   = 1'b1;
          out_ready = 1'b0;
          for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", out_valid, 1);
            chk("stall_addr", out_addr, ea);
            chk("stall_bit", out_bit, eb);
          end
          out_ready = 1'b1;
        end
        run = int'(out_run);
        chk("beat_addr", out_addr, ea);
        chk("beat_bit", out_bit, eb);
`ifndef GLYPH_ADDR_DEDUP_EN
        chk("beat_run", out_run, 1);
`endif
        chk("beat_eol", out_eol, (c + run == w));
        chk("beat_last", out_last, (c + run == w) && (r == h - 1));
        log_addr.push_back(int'(out_addr));
        log_bit.push_back(int'(out_bit));
        log_run.push_back(run);
        beats++;
        c += run;
        if (c >= w) begin
          c = 0;
          r++;
          eols++;
        end
        if (r == h) fin = 1'b1;
      end
      step();
      cyc++;
    end
    if (stop_at < 0) begin
      chk("drain_complete", fin, 1);
      chk("done_pulse", done, 1);
      chk("ready_at_done", req_ready, 1);
      chk("valid_after_last", out_valid, 0);
      step();
      chk("done_single", done, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; out_ready = 1'b1;
    req_font = 5'd0; req_char = 8'd0; req_dst_w = 16'd0; req_dst_h = 16'd0;
    req_step_x = 16'd0; req_step_y = 16'd0;
    step();
    step();
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", out_addr, 0);
    chk("rst_bit", out_bit, 0);
    chk("rst_run", out_run, 0);
    chk("rst_eol", out_eol, 0);
    chk("rst_last", out_last, 0);
    rst_n = 1'b1;
    step();
    chk("idle_ready", req_ready, 1);

    // font 1, char 'A', 1:1 scale over the full glyph
    send(1, 8'h41, 64, 128, 16'h0100, 16'h0100);
    chk("load_valid", out_valid, 0);
    chk("load_ready", req_ready, 0);
    step();
    chk("lat_e1_valid", out_valid, 0);
`ifndef GLYPH_ADDR_DEDUP_EN
    step();
    chk("lat_first_valid", out_valid, 1);
`endif
    drain(64, 128, 256, 256, 164352, -1, -1);
    chk("a_eols", eols, 128);
`ifndef GLYPH_ADDR_DEDUP_EN
    chk("a_beats", beats, 8192);
    chk("a_first_addr", log_addr[0], 164352);
    chk("a_first_bit", log_bit[0], 0);
    chk("a_c15_addr", log_addr[15], 164352);
    chk("a_c15_bit", log_bit[15], 15);
    chk("a_c16_addr", log_addr[16], 164353);
    chk("a_last_addr", log_addr[8191], 164863);
    chk("a_last_bit", log_bit[8191], 15);
`endif

    // 2x downscale: font 0, char 2
    send(0, 2, 32, 64, 16'h0200, 16'h0200);
    drain(32, 64, 512, 512, 1024, -1, -1);
`ifndef GLYPH_ADDR_DEDUP_EN
    chk("b_beats", beats, 2048);
    chk("b_c1_addr", log_addr[1], 1024);
    chk("b_c1_bit", log_bit[1], 2);
    chk("b_r1_addr", log_addr[32], 1032);
    chk("b_last_addr", log_addr[2047], 1531);
`endif

    // destination wider than the glyph saturates at the last column
    send(3, 8'hff, 200, 1, 16'h0100, 16'h0100);
    drain(200, 1, 256, 256, 523776, -1, -1);
    chk("c_eols", eols, 1);
`ifndef GLYPH_ADDR_DEDUP_EN
    chk("c_c62_bit", log_bit[62], 14);
    chk("c_c63_addr", log_addr[63], 523779);
    chk("c_c63_bit", log_bit[63], 15);
    chk("c_c199_addr", log_addr[199], 523779);
    chk("c_c199_bit", log_bit[199], 15);
`endif

    // zero-width request retires without beats
    send(1, 8'h41, 0, 5, 16'h0100, 16'h0100);
    chk("z_load_done", done, 0);
    chk("z_load_ready", req_ready, 0);
    step();
    chk("z_done", done, 1);
    chk("z_ready", req_ready, 1);
    chk("z_valid", out_valid, 0);
    step();
    chk("z_done_off", done, 0);
    chk("z_valid_off", out_valid, 0);

    // backpressure for 5 cycles mid-row
    send(2, 7, 64, 2, 16'h0100, 16'h0100);
    drain(64, 2, 256, 256, 265728, 20, -1);
    chk("d_eols", eols, 2);
`ifndef GLYPH_ADDR_DEDUP_EN
    chk("d_beats", beats, 128);
    chk("d_c20_addr", log_addr[20], 265729);
    chk("d_c20_bit", log_bit[20], 4);
`endif

    // reset mid-run drops the request; a fresh one then completes
    send(0, 5, 64, 4, 16'h0100, 16'h0100);
    drain(64, 4, 256, 256, 2560, -1, 10);
    rst_n = 1'b0;
    step();
    chk("mrst_valid", out_valid, 0);
    chk("mrst_done", done, 0);
    chk("mrst_ready", req_ready, 0);
    rst_n = 1'b1;
    step();
    chk("mrst_idle_ready", req_ready, 1);
    chk("mrst_no_done", done, 0);
    send(0, 1, 16, 2, 16'h0080, 16'h0080);
    drain(16, 2, 128, 128, 512, -1, -1);
    chk("e_eols", eols, 2);
`ifndef GLYPH_ADDR_DEDUP_EN
    chk("e_beats", beats, 32);
    chk("e_c3_bit", log_bit[3], 1);
    chk("e_last_addr", log_addr[31], 512);
    chk("e_last_bit", log_bit[31], 7);
`endif

`ifdef GLYPH_ADDR_DEDUP_EN
    // one row at 1:1 collapses to one beat per flash word
    send(1, 8'h41, 64, 1, 16'h0100, 16'h0100);
    drain(64, 1, 256, 256, 164352, -1, -1);
    chk("dd_beats", beats, 4);
    for (int i = 0; i < 4 && i < beats; i++) begin
      chk("dd_addr", log_addr[i], 164352 + i);
      chk("dd_run", log_run[i], 16);
      chk("dd_bit", log_bit[i], 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
